// File: rtl/pp_raster_pkg.sv
// Shared constants and types for the raster address generator.
package pp_raster_pkg;

    localparam int unsigned DIM_W   = 11;
    localparam int unsigned ADDR_W  = 2 * DIM_W;
    localparam int unsigned MUL_LAT = 3;

    typedef enum logic [1:0] {
        StIdle,
        StGen,
        StDrain
    } state_e;

    // Side-pipe entry travelling alongside the row-base multiply.
    typedef struct packed {
        logic             valid;
        logic [DIM_W-1:0] row;
        logic [DIM_W-1:0] col;
        logic             last;
    } side_t;

endpackage

// File: rtl/pp_pipeline_accel_raster_addr_gen_if.sv
// Address-beat stream: valid/ready handshake plus address, coordinates and last flag.
interface pp_pipeline_accel_raster_addr_gen_if;
    import pp_raster_pkg::*;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DIM_W-1:0]  m_row;
    logic [DIM_W-1:0]  m_col;
    logic              m_last;

    modport master (
        output m_valid,
        output m_addr,
        output m_row,
        output m_col,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_addr,
        input  m_row,
        input  m_col,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/pp_raster_row_mul.sv
// Three-stage unsigned DIM_W x DIM_W multiplier with clock enable.
// Stages: input registers, product register, output register. Datapath has no reset.
module pp_raster_row_mul
    import pp_raster_pkg::*;
(
    input  logic              clk_i,
    input  logic              ce_i,
    input  logic [DIM_W-1:0]  a_i,
    input  logic [DIM_W-1:0]  b_i,
    output logic [ADDR_W-1:0] p_o
);

    logic [DIM_W-1:0]  a_q;
    logic [DIM_W-1:0]  b_q;
    logic [ADDR_W-1:0] prod_q;
    logic [ADDR_W-1:0] out_q;

    // All stages advance together on ce and hold otherwise.
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            prod_q <= ADDR_W'(a_q) * ADDR_W'(b_q);
            out_q  <= prod_q;
        end
    end

    assign p_o = out_q;

endmodule

// File: rtl/pp_pipeline_accel_raster_addr_gen.sv
// Raster-scan address generator: walks row/col of a width x height frame and emits
// addr = row*width + col as a valid/ready stream with last and done flags.
// Optional macro PP_RASTER_ADDR_PITCH_EN adds a pitch input used as the row multiplier.
module pp_pipeline_accel_raster_addr_gen
    import pp_raster_pkg::*;
(
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     width,
    input  logic [DIM_W-1:0]     height,
`ifdef PP_RASTER_ADDR_PITCH_EN
    input  logic [DIM_W-1:0]     pitch,
`endif
    output logic                 busy,
    output logic                 done,
    pp_pipeline_accel_raster_addr_gen_if.master m
);

    state_e           state_q, state_d;
    logic [DIM_W-1:0] width_q, width_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic             done_q, done_d;
    logic [DIM_W-1:0] mul_b;
`ifdef PP_RASTER_ADDR_PITCH_EN
    logic [DIM_W-1:0] pitch_q, pitch_d;
`endif

    side_t             side_q [MUL_LAT];
    side_t             issue;
    side_t             out_s;
    logic              adv;
    logic              is_last;
    logic              col_wrap;
    logic [ADDR_W-1:0] mul_p;

    // Whole pipeline (counters, side pipe, multiplier) stalls only on a refused beat.
    assign adv      = !(m.m_valid && !m.m_ready);
    assign col_wrap = (col_q == width_q - DIM_W'(1));
    assign is_last  = col_wrap && (row_q == height_q - DIM_W'(1));

    // Next-state, counter stepping and issue into the multiply pipeline.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        issue    = '0;
`ifdef PP_RASTER_ADDR_PITCH_EN
        pitch_d  = pitch_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (width != '0 && height != '0) begin
                        width_d  = width;
                        height_d = height;
`ifdef PP_RASTER_ADDR_PITCH_EN
                        pitch_d  = pitch;
`endif
                        row_d    = '0;
                        col_d    = '0;
                        state_d  = StGen;
                    end else begin
                        // Empty frame: finish immediately without any beats.
                        done_d = 1'b1;
                    end
                end
            end
            StGen: begin
                if (adv) begin
                    issue.valid = 1'b1;
                    issue.row   = row_q;
                    issue.col   = col_q;
                    issue.last  = is_last;
                    if (is_last) begin
                        state_d = StDrain;
                    end else if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            StDrain: begin
                if (m.m_valid && m.m_ready && m.m_last) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and counter state registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= StIdle;
            width_q  <= '0;
            height_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            done_q   <= 1'b0;
`ifdef PP_RASTER_ADDR_PITCH_EN
            pitch_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            row_q    <= row_d;
            col_q    <= col_d;
            done_q   <= done_d;
`ifdef PP_RASTER_ADDR_PITCH_EN
            pitch_q  <= pitch_d;
`endif
        end
    end

    // Side pipe matching the multiplier latency; bubbles carry valid=0.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                side_q[i] <= '0;
            end
        end else if (adv) begin
            side_q[0] <= issue;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

`ifdef PP_RASTER_ADDR_PITCH_EN
    assign mul_b = pitch_q;
`else
    assign mul_b = width_q;
`endif

    pp_raster_row_mul u_row_mul (
        .clk_i (ap_clk),
        .ce_i  (adv),
        .a_i   (issue.row),
        .b_i   (mul_b),
        .p_o   (mul_p)
    );

    assign out_s = side_q[MUL_LAT-1];

    assign m.m_valid = out_s.valid;
    assign m.m_row   = out_s.row;
    assign m.m_col   = out_s.col;
    assign m.m_last  = out_s.last;
    // Multiplier datapath is unreset, so mask the address when no beat is present.
    assign m.m_addr  = out_s.valid ? (mul_p + ADDR_W'(out_s.col)) : '0;

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_pp_pipeline_accel_raster_addr_gen.sv
// Scoreboard bench for the raster address generator.
module tb_pp_pipeline_accel_raster_addr_gen;
    import pp_raster_pkg::*;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             start  = 1'b0;
    logic [DIM_W-1:0] width  = '0;
    logic [DIM_W-1:0] height = '0;
`ifdef PP_RASTER_ADDR_PITCH_EN
    logic [DIM_W-1:0] pitch  = '0;
    int               pitch_val = 0;
`endif
    logic             busy;
    logic             done;

    logic              mul_ce = 1'b0;
    logic [DIM_W-1:0]  mul_a  = '0;
    logic [DIM_W-1:0]  mul_b  = '0;
    logic [ADDR_W-1:0] mul_p;

    pp_pipeline_accel_raster_addr_gen_if m_if ();

    pp_pipeline_accel_raster_addr_gen u_dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .start  (start),
        .width  (width),
        .height (height),
`ifdef PP_RASTER_ADDR_PITCH_EN
        .pitch  (pitch),
`endif
        .busy   (busy),
        .done   (done),
        .m      (m_if.master)
    );

    pp_raster_row_mul u_mul (
        .clk_i (clk),
        .ce_i  (mul_ce),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (mul_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DIM_W-1:0]  row;
        logic [DIM_W-1:0]  col;
        logic              last;
    } beat_t;

    beat_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cycle_cnt = 0;
    int beats_acc = 0;
    int done_cnt = 0;
    int done_base = 0;
    int done_cyc = -1;
    int last_cyc = -1;
    int first_cyc = -1;
    int t_start = 0;
    bit seen_valid = 1'b0;
    bit mon_en = 1'b1;
    int rdy_mode = 0;
    int hold_left = 0;
    bit hold_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycle_cnt++;
    end

    // Output monitor: compares every presented beat (stalled or not) to the queue head.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cycle_cnt;
            end
            if (m_if.m_valid && mon_en) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    first_cyc  = cycle_cnt;
                end
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_eq("beat",
                             {m_if.m_addr, m_if.m_row, m_if.m_col, m_if.m_last},
                             {exp_q[0].addr, exp_q[0].row, exp_q[0].col, exp_q[0].last});
                    if (m_if.m_ready) begin
                        void'(exp_q.pop_front());
                        beats_acc++;
                        last_cyc = cycle_cnt;
                    end
                end
            end
        end
    end

    // Downstream ready: always high, or random with one 7-cycle hold at beat 3.
    initial begin
        m_if.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                m_if.m_ready = 1'b1;
            end else if (hold_left > 0) begin
                m_if.m_ready = 1'b0;
                hold_left--;
            end else if (beats_acc == 3 && !hold_done) begin
                m_if.m_ready = 1'b0;
                hold_left = 6;
                hold_done = 1'b1;
            end else begin
                m_if.m_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Called just after a posedge: pushes the expected frame and pulses start for one cycle.
    task automatic start_frame(input int w, input int h);
        int pm;
        pm = w;
`ifdef PP_RASTER_ADDR_PITCH_EN
        if (pitch_val != 0) pm = pitch_val;
        pitch = DIM_W'(pm);
`endif
        if (w != 0 && h != 0) begin
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    beat_t b;
                    b.addr = ADDR_W'(r * pm + c);
                    b.row  = DIM_W'(r);
                    b.col  = DIM_W'(c);
                    b.last = (r == h - 1) && (c == w - 1);
                    exp_q.push_back(b);
                end
            end
        end
        seen_valid = 1'b0;
        done_base  = done_cnt;
        beats_acc  = 0;
        t_start    = cycle_cnt;
        width      = DIM_W'(w);
        height     = DIM_W'(h);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_done_cnt"}, 64'(done_cnt - done_base), 64'd1);
        check_eq({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_valid", 64'(m_if.m_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_addr", 64'(m_if.m_addr), 64'd0);
        check_eq("rst_rowcol", 64'({m_if.m_row, m_if.m_col, m_if.m_last}), 64'd0);

        // Multiplier corners, including the largest product.
        mul_ce = 1'b1; mul_a = 11'd2047; mul_b = 11'd2047;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mul_max", 64'(mul_p), 64'd4190209);
        mul_a = 11'd1234; mul_b = 11'd567;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mul_mid", 64'(mul_p), 64'd699678);
        mul_ce = 1'b0; mul_a = 11'd5; mul_b = 11'd5;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mul_hold", 64'(mul_p), 64'd699678);

        // Normal 4x3 frame.
        start_frame(4, 3);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_done(200, "t1");
        check_eq("t1_latency", 64'(first_cyc - t_start), 64'd4);
        check_eq("t1_done_lat", 64'(done_cyc - last_cyc), 64'd1);

        // Random backpressure with a long hold on beat 3.
        rdy_mode  = 1;
        hold_done = 1'b0;
        hold_left = 0;
        start_frame(5, 2);
        wait_done(600, "t2");
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Empty frame.
        start_frame(0, 7);
        wait_done(30, "t3");
        check_eq("t3_no_valid", 64'(seen_valid), 64'd0);
        check_eq("t3_done_lat", 64'(done_cyc - t_start), 64'd1);

        // 1x1 frame.
        start_frame(1, 1);
        wait_done(30, "t4");
        check_eq("t4_done_lat", 64'(done_cyc - last_cyc), 64'd1);

        // Widest rows: exercises wrap at col 2046.
        start_frame(2047, 3);
        wait_done(7000, "t5");

        // Start pulsed mid-frame must be ignored.
        start_frame(4, 3);
        repeat (5) @(posedge clk);
        #1;
        width = 11'd2; height = 11'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, "t6");

        // Reset at beat 6 of a 4x4 frame aborts without done.
        start_frame(4, 4);
        n = 0;
        while (beats_acc < 6 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("t7_reached_beat6", 64'(beats_acc >= 6), 64'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("t7_valid_after_rst", 64'(m_if.m_valid), 64'd0);
        check_eq("t7_busy_after_rst", 64'(busy), 64'd0);
        done_base = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t7_no_done", 64'(done_cnt - done_base), 64'd0);
        exp_q.delete();
        mon_en = 1'b1;

        // Clean frame after reset.
        start_frame(4, 4);
        wait_done(200, "t8");
        check_eq("t8_latency", 64'(first_cyc - t_start), 64'd4);

`ifdef PP_RASTER_ADDR_PITCH_EN
        pitch_val = 8;
        start_frame(3, 2);
        wait_done(100, "t9");
        pitch_val = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
